event_debouncer: RTL and testbench

EVENT_DEBOUNCER -- requirements
Module: event_debouncer

---
 rtl/event_debouncer.sv | 143 ++++++++++++++
 tb/tb_event_debouncer.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/event_debouncer.sv
// rtl/event_debouncer.sv - synchronized, qualified button/event debouncer with edge pulses and glitch counter
module event_debouncer #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int GLITCH_WIDTH    = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    btn_in,
    input  logic                    clr_glitch,
    output logic                    stable,
    output logic                    rise_pulse,
    output logic                    fall_pulse,
    output logic [GLITCH_WIDTH-1:0] glitch_cnt
);

    localparam int                CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [GLITCH_WIDTH-1:0] GLITCH_ONE = GLITCH_WIDTH'(1);

    typedef enum logic [1:0] {
        LOW,
        RISE_WAIT,
        HIGH,
        FALL_WAIT
    } state_t;

    logic [SYNC_STAGES-1:0]  sync_q;
    logic                    sync_out;
    state_t                  state_q;
    logic [CNT_W-1:0]        cnt_q;
    logic                    stable_q;
    logic                    rise_q;
    logic                    fall_q;
    logic [GLITCH_WIDTH-1:0] glitch_q;
    logic                    glitch_abort;

    // btn_in is asynchronous: only the first stage of this chain may sample it
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], btn_in};
        end
    end

    assign sync_out = sync_q[SYNC_STAGES-1];

    always_comb begin
        glitch_abort = 1'b0;
        if ((state_q == RISE_WAIT && !sync_out) || (state_q == FALL_WAIT && sync_out)) begin
            glitch_abort = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= LOW;
            cnt_q    <= '0;
            stable_q <= 1'b0;
            rise_q   <= 1'b0;
            fall_q   <= 1'b0;
        end else begin
            rise_q <= 1'b0;
            fall_q <= 1'b0;
            case (state_q)
                LOW: begin
                    if (sync_out) begin
                        if (DEBOUNCE_CYCLES == 1) begin
                            state_q  <= HIGH;
                            cnt_q    <= '0;
                            stable_q <= 1'b1;
                            rise_q   <= 1'b1;
                        end else begin
                            state_q <= RISE_WAIT;
                            cnt_q   <= CNT_ONE;
                        end
                    end
                end
                RISE_WAIT: begin
                    if (!sync_out) begin
                        state_q <= LOW;
                        cnt_q   <= '0;
                    end else if (cnt_q == CNT_LAST) begin
                        state_q  <= HIGH;
                        cnt_q    <= '0;
                        stable_q <= 1'b1;
                        rise_q   <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + CNT_ONE;
                    end
                end
                HIGH: begin
                    if (!sync_out) begin
                        if (DEBOUNCE_CYCLES == 1) begin
                            state_q  <= LOW;
                            cnt_q    <= '0;
                            stable_q <= 1'b0;
                            fall_q   <= 1'b1;
                        end else begin
                            state_q <= FALL_WAIT;
                            cnt_q   <= CNT_ONE;
                        end
                    end
                end
                FALL_WAIT: begin
                    if (sync_out) begin
                        state_q <= HIGH;
                        cnt_q   <= '0;
                    end else if (cnt_q == CNT_LAST) begin
                        state_q  <= LOW;
                        cnt_q    <= '0;
                        stable_q <= 1'b0;
                        fall_q   <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + CNT_ONE;
                    end
                end
                default: begin
                    state_q  <= LOW;
                    cnt_q    <= '0;
                    stable_q <= 1'b0;
                end
            endcase
        end
    end

    // Clear takes priority over a coincident abort; the count saturates rather than wraps
    always_ff @(posedge clk) begin
        if (!rst_n || clr_glitch) begin
            glitch_q <= '0;
        end else if (glitch_abort && (glitch_q != {GLITCH_WIDTH{1'b1}})) begin
            glitch_q <= glitch_q + GLITCH_ONE;
        end
    end

    assign stable     = stable_q;
    assign rise_pulse = rise_q;
    assign fall_pulse = fall_q;
    assign glitch_cnt = glitch_q;

endmodule

// File: tb/tb_event_debouncer.sv
// tb/tb_event_debouncer.sv - scoreboard bench for event_debouncer against a run-length reference model
module tb_event_debouncer;

    localparam int SYNC = 2;
    localparam int DEB  = 4;
    localparam int GW   = 8;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          btn_in;
    logic          clr_glitch;
    logic          stable;
    logic          rise_pulse;
    logic          fall_pulse;
    logic [GW-1:0] glitch_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct packed {
        logic          st;
        logic          rs;
        logic          fl;
        logic [GW-1:0] gc;
    } exp_t;

    exp_t sb_q[$];

    logic [SYNC-1:0] m_sync;
    logic            m_stable;
    int              m_run;
    logic [GW-1:0]   m_gc;
    logic            last_rise;

    always #5 clk = ~clk;

    event_debouncer #(
        .SYNC_STAGES    (SYNC),
        .DEBOUNCE_CYCLES(DEB),
        .GLITCH_WIDTH   (GW)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .btn_in    (btn_in),
        .clr_glitch(clr_glitch),
        .stable    (stable),
        .rise_pulse(rise_pulse),
        .fall_pulse(fall_pulse),
        .glitch_cnt(glitch_cnt)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
        end
    endtask

    // Reference: level flips after DEB consecutive synchronized samples that differ from it
    always @(posedge clk) begin
        exp_t e;
        logic s;
        e = '0;
        if (!rst_n) begin
            m_sync   = '0;
            m_stable = 1'b0;
            m_run    = 0;
            m_gc     = '0;
        end else begin
            s      = m_sync[SYNC-1];
            m_sync = {m_sync[SYNC-2:0], btn_in};
            if (s != m_stable) begin
                m_run++;
                if (m_run == DEB) begin
                    m_stable = s;
                    m_run    = 0;
                    e.rs     = s;
                    e.fl     = !s;
                end
            end else begin
                if (m_run > 0 && m_gc != {GW{1'b1}}) m_gc++;
                m_run = 0;
            end
            if (clr_glitch) m_gc = '0;
        end
        e.st = m_stable;
        e.gc = m_gc;
        sb_q.push_back(e);
    end

    always @(posedge clk) begin
        exp_t e;
        #1;
        check_eq("sb_depth", sb_q.size(), 1);
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            check_eq("stable", stable, e.st);
            check_eq("rise_pulse", rise_pulse, e.rs);
            check_eq("fall_pulse", fall_pulse, e.fl);
            check_eq("glitch_cnt", glitch_cnt, e.gc);
        end
        if (!rst_n) begin
            last_rise = 1'b0;
        end else begin
            if (rise_pulse) begin
                check_eq("alt_rise", last_rise, 0);
                last_rise = 1'b1;
            end
            if (fall_pulse) begin
                check_eq("alt_fall", last_rise, 1);
                last_rise = 1'b0;
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic meas(input bit want_rise, output int lat);
        lat = 0;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk);
            #2;
            if (want_rise ? rise_pulse : fall_pulse) begin
                lat = i;
                break;
            end
        end
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog expired t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int nr;
        rst_n      = 1'b0;
        btn_in     = 1'b0;
        clr_glitch = 1'b0;
        tick(3);
        check_eq("rst_stable", stable, 0);
        check_eq("rst_rise", rise_pulse, 0);
        check_eq("rst_glitch", glitch_cnt, 0);
        rst_n = 1'b1;
        tick(2);

        // clean step up and hold
        btn_in = 1'b1;
        meas(1'b1, lat);
        check_eq("rise_lat", lat, 6);
        check_eq("rise_stable", stable, 1);
        @(posedge clk); #2;
        check_eq("rise_one_cycle", rise_pulse, 0);
        check_eq("step_glitch", glitch_cnt, 0);

        // drop for 10 cycles, then raise again
        @(negedge clk);
        btn_in = 1'b0;
        meas(1'b0, lat);
        check_eq("fall_lat", lat, 6);
        check_eq("fall_stable", stable, 0);
        tick(5);
        btn_in = 1'b1;
        meas(1'b1, lat);
        check_eq("rerise_lat", lat, 6);
        @(negedge clk);
        btn_in = 1'b0;
        meas(1'b0, lat);
        check_eq("refall_lat", lat, 6);
        tick(4);

        // 3-cycle glitch from LOW
        btn_in = 1'b1;
        tick(3);
        btn_in = 1'b0;
        tick(6);
        check_eq("glitch3_stable", stable, 0);
        check_eq("glitch3_cnt", glitch_cnt, 1);

        // saturation
        repeat (300) begin
            btn_in = 1'b1;
            tick(2);
            btn_in = 1'b0;
            tick(4);
        end
        check_eq("glitch_sat", glitch_cnt, 255);

        // clear coinciding with an abort edge
        btn_in = 1'b1;
        tick(2);
        btn_in = 1'b0;
        tick(2);
        clr_glitch = 1'b1;
        tick(1);
        clr_glitch = 1'b0;
        check_eq("clr_wins", glitch_cnt, 0);
        tick(4);

        // reset during RISE_WAIT with btn held high
        btn_in = 1'b1;
        tick(4);
        rst_n = 1'b0;
        tick(1);
        check_eq("midrst_stable", stable, 0);
        check_eq("midrst_rise", rise_pulse, 0);
        check_eq("midrst_fall", fall_pulse, 0);
        tick(1);
        rst_n = 1'b1;
        meas(1'b1, lat);
        check_eq("postrst_lat", lat, 6);
        nr = 0;
        repeat (20) begin
            @(posedge clk); #2;
            if (rise_pulse) nr++;
        end
        check_eq("postrst_extra_rise", nr, 0);

        // random toggling
        @(negedge clk);
        repeat (300) begin
            btn_in = ~btn_in;
            tick($urandom_range(1, 10));
        end
        btn_in = 1'b0;
        tick(20);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
